// File: rtl/mac_operand_negator_pipe_pkg.sv
// Shared constants for the configurable MAC: fuse-mode encodings, cfg bit
// positions and the group-size decode used by the sign-magnitude stage.
package mac_operand_negator_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10,
    MODE_RSVD   = 2'b11
  } fuse_mode_e;

  localparam int CFG_SIGNED_BIT = 3;

  // Lanes per fused group; the reserved encoding behaves as single-lane.
  function automatic logic [3:0] group_size(input fuse_mode_e mode, input int num_lanes);
    logic [3:0] g;
    case (mode)
      MODE_DUAL: g = 4'd2;
      MODE_QUAD: g = 4'd4;
      default:   g = 4'd1;
    endcase
    if (int'(g) > num_lanes) g = 4'(num_lanes);
    return g;
  endfunction

endpackage

// File: rtl/mac_group_negator.sv
// Combinational two's-complement-to-magnitude conversion over fused lane
// groups, with per-lane group sign and most-negative-value flag.
module mac_group_negator #(
  parameter int W         = 8,
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES*W-1:0] data_i,
  input  logic [3:0]             group_lanes_i,
  input  logic                   signed_i,
  output logic [NUM_LANES*W-1:0] mag_o,
  output logic [NUM_LANES-1:0]   sign_o,
  output logic [NUM_LANES-1:0]   min_o
);

  localparam logic [W-1:0] MIN_LANE = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    int         g;
    int         top;
    logic       carry;
    logic       is_min;
    logic [W:0] sum;
    logic [W-1:0] x;
    // NOTE: every output and temporary gets a value before any branch so
    // this block stays purely combinational and never infers a latch.
    mag_o  = '0;
    sign_o = '0;
    min_o  = '0;
    carry  = 1'b1;
    is_min = 1'b0;
    sum    = '0;
    x      = '0;
    top    = 0;
    g      = int'(group_lanes_i);
    for (int i = 0; i < NUM_LANES; i++) begin
      top = i | (g - 1);
      x   = data_i[i*W +: W];
      // Carry chain restarts at each group's lowest lane: ~x + 1 per group.
      if ((i & (g - 1)) == 0) carry = 1'b1;
      sum   = {1'b0, ~x} + {{W{1'b0}}, carry};
      carry = sum[W];
      sign_o[i] = data_i[top*W + W - 1];
      mag_o[i*W +: W] = (signed_i && sign_o[i]) ? sum[W-1:0] : x;
      is_min = 1'b1;
      for (int j = 0; j < NUM_LANES; j++) begin
        if ((j & ~(g - 1)) == (i & ~(g - 1))) begin
          if (j == top) is_min &= (data_i[j*W +: W] == MIN_LANE);
          else          is_min &= (data_i[j*W +: W] == '0);
        end
      end
      min_o[i] = signed_i && is_min;
    end
  end

endmodule

// File: rtl/mac_operand_negator_pipe.sv
// Two-stage valid/ready pipeline converting fused signed operand groups to
// magnitudes and reporting per-lane product sign and most-negative flags.
module mac_operand_negator_pipe
  import mac_operand_negator_pipe_pkg::*;
#(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int NUM_LANES      = 4,
  parameter int MAC_CONF_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]         cfg,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_in,
  input  logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANES*MAC_MIN_WIDTH-1:0] A_out,
  output logic [NUM_LANES*MAC_MIN_WIDTH-1:0] B_out,
  output logic [NUM_LANES-1:0]              C_neg,
  output logic [NUM_LANES-1:0]              A_min,
  output logic [NUM_LANES-1:0]              B_min,
  output logic [MAC_CONF_WIDTH-1:0]         cfg_out
);

  localparam int DW = NUM_LANES * MAC_MIN_WIDTH;

  logic                      s1_valid_q, s1_valid_d;
  logic [DW-1:0]             s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg_q, s1_cfg_d;

  logic                      s2_valid_q, s2_valid_d;
  logic [DW-1:0]             s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [NUM_LANES-1:0]      s2_cneg_q, s2_cneg_d;
  logic [NUM_LANES-1:0]      s2_amin_q, s2_amin_d, s2_bmin_q, s2_bmin_d;
  logic [MAC_CONF_WIDTH-1:0] s2_cfg_q, s2_cfg_d;

  logic                 accept, s2_load, is_signed;
  logic [3:0]           grp_lanes;
  logic [DW-1:0]        a_mag, b_mag;
  logic [NUM_LANES-1:0] a_sign, b_sign, a_min, b_min;

  // in_ready is the one intentional combinational path (from out_ready).
  assign in_ready  = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign s2_load   = !s2_valid_q || out_ready;
  assign is_signed = s1_cfg_q[CFG_SIGNED_BIT];
  assign grp_lanes = group_size(fuse_mode_e'(s1_cfg_q[1:0]), NUM_LANES);

  mac_group_negator #(.W(MAC_MIN_WIDTH), .NUM_LANES(NUM_LANES)) u_neg_a (
    .data_i        (s1_a_q),
    .group_lanes_i (grp_lanes),
    .signed_i      (is_signed),
    .mag_o         (a_mag),
    .sign_o        (a_sign),
    .min_o         (a_min)
  );

  mac_group_negator #(.W(MAC_MIN_WIDTH), .NUM_LANES(NUM_LANES)) u_neg_b (
    .data_i        (s1_b_q),
    .group_lanes_i (grp_lanes),
    .signed_i      (is_signed),
    .mag_o         (b_mag),
    .sign_o        (b_sign),
    .min_o         (b_min)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cfg_d   = s1_cfg_q;
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_cneg_d  = s2_cneg_q;
    s2_amin_d  = s2_amin_q;
    s2_bmin_d  = s2_bmin_q;
    s2_cfg_d   = s2_cfg_q;

    if (s2_load) begin
      s1_valid_d = 1'b0;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_a_d    = a_mag;
        s2_b_d    = b_mag;
        s2_cneg_d = (a_sign ^ b_sign) & {NUM_LANES{is_signed}};
        s2_amin_d = a_min;
        s2_bmin_d = b_min;
        s2_cfg_d  = s1_cfg_q;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A_in;
      s1_b_d     = B_in;
      s1_cfg_d   = cfg;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so every output reads zero
    // straight after reset rather than stale payload.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cfg_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_cneg_q  <= '0;
      s2_amin_q  <= '0;
      s2_bmin_q  <= '0;
      s2_cfg_q   <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling the
      // pre-edge state, regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cfg_q   <= s1_cfg_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_cneg_q  <= s2_cneg_d;
      s2_amin_q  <= s2_amin_d;
      s2_bmin_q  <= s2_bmin_d;
      s2_cfg_q   <= s2_cfg_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign A_out     = s2_a_q;
  assign B_out     = s2_b_q;
  assign C_neg     = s2_cneg_q;
  assign A_min     = s2_amin_q;
  assign B_min     = s2_bmin_q;
  assign cfg_out   = s2_cfg_q;

endmodule

// File: tb/tb_mac_operand_negator_pipe.sv
// Self-checking bench: directed vectors with literal expectations plus a
// group-arithmetic reference model and FIFO scoreboard checked every cycle.
module tb_mac_operand_negator_pipe;

  localparam int W  = 8;
  localparam int NL = 4;
  localparam int CW = 4;
  localparam int DW = NL * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] cfg, cfg_out;
  logic [DW-1:0] A_in, B_in, A_out, B_out;
  logic [NL-1:0] C_neg, A_min, B_min;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [NL-1:0] cneg;
    logic [NL-1:0] amin;
    logic [NL-1:0] bmin;
    logic [CW-1:0] cfg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mac_operand_negator_pipe #(
    .MAC_MIN_WIDTH  (W),
    .NUM_LANES      (NL),
    .MAC_CONF_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg       (cfg),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .C_neg     (C_neg),
    .A_min     (A_min),
    .B_min     (B_min),
    .cfg_out   (cfg_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic int group_of(input logic [CW-1:0] c);
    int g;
    case (c[1:0])
      2'b01:   g = 2;
      2'b10:   g = 4;
      default: g = 1;
    endcase
    if (g > NL) g = NL;
    return g;
  endfunction

  // Treats each group as one integer of g*W bits and negates it arithmetically.
  function automatic void conv(input logic [DW-1:0] x, input int g, input bit sgn,
                               output logic [DW-1:0] mag, output logic [NL-1:0] sign,
                               output logic [NL-1:0] mn);
    longint unsigned full, half, v;
    int gw;
    gw   = g * W;
    full = 64'd1 << gw;
    half = full >> 1;
    mag  = '0;
    sign = '0;
    mn   = '0;
    for (int k = 0; k < NL / g; k++) begin
      v = ({32'd0, x} >> (k * gw)) % full;
      for (int l = k * g; l < k * g + g; l++) begin
        sign[l] = (v >= half);
        mn[l]   = sgn && (v == half);
      end
      if (sgn && v >= half) v = full - v;
      mag = mag | DW'(v << (k * gw));
    end
  endfunction

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [CW-1:0] c);
    exp_t          e;
    logic [NL-1:0] sa, sb_s;
    bit            sgn;
    int            g;
    sgn = c[3];
    g   = group_of(c);
    conv(a, g, sgn, e.a, sa, e.amin);
    conv(b, g, sgn, e.b, sb_s, e.bmin);
    e.cneg = sgn ? (sa ^ sb_s) : '0;
    e.cfg  = c;
    return e;
  endfunction

  // Scoreboard: every valid output must match the oldest accepted transaction.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", out_valid, 1'b0);
        end else begin
          check("sb_out", {A_out, B_out, C_neg, A_min, B_min, cfg_out}, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(model(A_in, B_in, cfg));
    end
  end

  task automatic send_one(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [CW-1:0] c, input logic [DW-1:0] ea,
                          input logic [DW-1:0] eb, input logic [NL-1:0] ecn,
                          input logic [NL-1:0] eam, input logic [NL-1:0] ebm);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    A_in     = a;
    B_in     = b;
    cfg      = c;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat1_valid"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, "_lat2_valid"}, out_valid, 1'b1);
    check({name, "_data"}, {A_out, B_out, C_neg, A_min, B_min, cfg_out},
          {ea, eb, ecn, eam, ebm, c});
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    in_valid = 1'b1;
    A_in     = a;
    B_in     = b;
    cfg      = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit accepted;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cfg       = '0;
    A_in      = '0;
    B_in      = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_outputs", {A_out, B_out, C_neg, A_min, B_min, cfg_out}, '0);

    send_one("single", 32'h7F05FF80, 32'hFEFEFEFE, 4'h8,
             32'h7F050180, 32'h02020202, 4'b1100, 4'b0001, 4'b0000);
    send_one("dual", 32'hFFFE0001, 32'h00020003, 4'h9,
             32'h00020001, 32'h00020003, 4'b1100, 4'b0000, 4'b0000);
    send_one("dual_min", 32'h7FFF8000, 32'hFFFFFFFF, 4'h9,
             32'h7FFF8000, 32'h00010001, 4'b1100, 4'b0011, 4'b0000);
    send_one("quad_neg", 32'hFFFFFF00, 32'h00000003, 4'hA,
             32'h00000100, 32'h00000003, 4'b1111, 4'b0000, 4'b0000);
    send_one("quad_min", 32'h80000000, 32'h00000003, 4'hA,
             32'h80000000, 32'h00000003, 4'b1111, 4'b1111, 4'b0000);
    send_one("unsigned_quad", 32'hFFFFFFFF, 32'h80000000, 4'h2,
             32'hFFFFFFFF, 32'h80000000, 4'b0000, 4'b0000, 4'b0000);
    send_one("mode11_single", 32'h00FF00FF, 32'h00000000, 4'hB,
             32'h00010001, 32'h00000000, 4'b0101, 4'b0000, 4'b0000);

    // Backpressure: three back-to-back transactions, downstream stalled.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(32'h7F05FF80, 32'hFEFEFEFE, 4'h8);
    @(negedge clk);
    check("bp_acc1_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 drive(32'hFFFE0001, 32'h00020003, 4'h9);
    @(negedge clk);
    check("bp_acc2_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 drive(32'hFFFFFF00, 32'h00000003, 4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_ready", in_ready, 1'b0);
      check("bp_full_out_valid", out_valid, 1'b1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    check("bp_third_accepted", accepted, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) break;
    end
    check("bp_drain_empty", sb.size(), 0);

    // Reset with both stages full discards everything in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(32'h11223344, 32'h55667788, 4'h8);
    @(negedge clk);
    check("rstfull_acc1", in_ready, 1'b1);
    @(posedge clk);
    #1 drive(32'h99AABBCC, 32'hDDEEFF00, 4'hA);
    @(negedge clk);
    check("rstfull_acc2", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("rstfull_in_ready_in_rst", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rstfull_out_valid", out_valid, 1'b0);
    check("rstfull_outputs", {A_out, B_out, C_neg, A_min, B_min, cfg_out}, '0);
    check("rstfull_in_ready", in_ready, 1'b1);

    send_one("after_rst_dual", 32'hFF00FF00, 32'h80000000, 4'h9,
             32'h01000100, 32'h80000000, 4'b0011, 4'b0000, 4'b1100);

    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
